// File: rtl/fp_normalizer.sv
// Post-add normalisation stage: iterative one-bit-per-clock left shifter that
// packs {sign, exp, frac} with truncation and flags overflow / subnormal results.
module fp_normalizer #(
  parameter int MANT_W = 11,
  parameter int EXP_W  = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [MANT_W-1:0]       in_mant,
  input  logic                    in_carry,
  input  logic [EXP_W-1:0]        in_exp,
  input  logic                    in_sign,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [EXP_W+MANT_W-1:0] out_result,
  output logic                    out_ovf,
  output logic                    out_unf
);

  localparam int RES_W = EXP_W + MANT_W;
  localparam logic [EXP_W:0] EXP_MAX = {1'b0, {EXP_W{1'b1}}};
  localparam logic [EXP_W:0] EXP_ONE = (EXP_W+1)'(1);

  typedef enum logic [1:0] {S_IDLE, S_NORM, S_DONE} state_t;

  state_t             r_state, w_state_next;
  logic [MANT_W-1:0]  r_mant, w_mant_next;
  logic [EXP_W:0]     r_exp, w_exp_next;
  logic               r_sign, w_sign_next;
  logic               r_ovf_pend, w_ovf_pend_next;
  logic [RES_W-1:0]   r_result, w_result_next;
  logic               r_ovf, w_ovf_next;
  logic               r_unf, w_unf_next;

  // Exponent carried one bit wider so the carry increment cannot wrap.
  logic [EXP_W:0]     w_exp_inc;
  assign w_exp_inc = {1'b0, in_exp} + EXP_ONE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_mant     <= '0;
      r_exp      <= '0;
      r_sign     <= 1'b0;
      r_ovf_pend <= 1'b0;
      r_result   <= '0;
      r_ovf      <= 1'b0;
      r_unf      <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_mant     <= w_mant_next;
      r_exp      <= w_exp_next;
      r_sign     <= w_sign_next;
      r_ovf_pend <= w_ovf_pend_next;
      r_result   <= w_result_next;
      r_ovf      <= w_ovf_next;
      r_unf      <= w_unf_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_mant_next     = r_mant;
    w_exp_next      = r_exp;
    w_sign_next     = r_sign;
    w_ovf_pend_next = r_ovf_pend;
    w_result_next   = r_result;
    w_ovf_next      = r_ovf;
    w_unf_next      = r_unf;

    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_sign_next  = in_sign;
          w_state_next = S_NORM;
          if (in_carry) begin
            w_mant_next     = {1'b1, in_mant[MANT_W-1:1]};
            w_exp_next      = w_exp_inc;
            w_ovf_pend_next = (w_exp_inc >= EXP_MAX);
          end else begin
            w_mant_next     = in_mant;
            w_exp_next      = {1'b0, in_exp};
            w_ovf_pend_next = 1'b0;
          end
        end
      end

      S_NORM: begin
        if (r_ovf_pend) begin
          w_result_next = {r_sign, {EXP_W{1'b1}}, {(MANT_W-1){1'b0}}};
          w_ovf_next    = 1'b1;
          w_unf_next    = 1'b0;
          w_state_next  = S_DONE;
        end else if (r_mant == '0) begin
          w_result_next = '0;
          w_ovf_next    = 1'b0;
          w_unf_next    = 1'b0;
          w_state_next  = S_DONE;
        end else if (r_mant[MANT_W-1]) begin
          w_result_next = {r_sign, r_exp[EXP_W-1:0], r_mant[MANT_W-2:0]};
          w_ovf_next    = 1'b0;
          w_unf_next    = 1'b0;
          w_state_next  = S_DONE;
        end else if (r_exp <= EXP_ONE) begin
          // Out of exponent range: emit subnormal with whatever is left.
          w_result_next = {r_sign, {EXP_W{1'b0}}, r_mant[MANT_W-2:0]};
          w_ovf_next    = 1'b0;
          w_unf_next    = 1'b1;
          w_state_next  = S_DONE;
        end else begin
          w_mant_next = {r_mant[MANT_W-2:0], 1'b0};
          w_exp_next  = r_exp - EXP_ONE;
        end
      end

      S_DONE: begin
        if (out_ready) w_state_next = S_IDLE;
      end

      default: w_state_next = S_IDLE;
    endcase
  end

  assign in_ready   = (r_state == S_IDLE);
  assign out_valid  = (r_state == S_DONE);
  assign out_result = r_result;
  assign out_ovf    = r_ovf;
  assign out_unf    = r_unf;

endmodule

// File: tb/tb_fp_normalizer.sv
// Scoreboard bench for fp_normalizer: directed corner cases plus randomized
// items checked against an arithmetic (leading-zero count) reference model.
module tb_fp_normalizer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [10:0] in_mant;
  logic        in_carry;
  logic [4:0]  in_exp;
  logic        in_sign;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_result;
  logic        out_ovf;
  logic        out_unf;

  fp_normalizer #(.MANT_W(11), .EXP_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_mant(in_mant), .in_carry(in_carry), .in_exp(in_exp), .in_sign(in_sign),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_ovf(out_ovf), .out_unf(out_unf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] res;
    logic        ovf;
    logic        unf;
    int          lat;
    int          acc_cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   txn = 0;
  int   stall_hold = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference: normalise by counting leading zeros, limited by exponent room.
  function automatic exp_t model(input logic [10:0] m_in, input logic c,
                                 input logic [4:0] e_in, input logic s);
    exp_t r;
    int m, e, lz, room, k;
    m = int'(m_in);
    e = int'(e_in);
    r.ovf = 1'b0; r.unf = 1'b0; r.lat = 1; r.acc_cyc = 0; r.res = '0;
    if (c) begin
      m = (m >> 1) | 1024;
      e = e + 1;
      if (e >= 31) begin
        r.res = {s, 5'h1f, 10'h000};
        r.ovf = 1'b1;
        return r;
      end
    end
    if (m == 0) return r;
    lz = 0;
    while (lz < 11 && (m & (1024 >> lz)) == 0) lz++;
    room = (e > 1) ? e - 1 : 0;
    k = (lz < room) ? lz : room;
    m = (m << k) & 2047;
    e = e - k;
    r.lat = k + 1;
    if (k == lz) r.res = {s, 5'(e), 10'(m & 1023)};
    else begin
      r.res = {s, 5'b00000, 10'(m & 1023)};
      r.unf = 1'b1;
    end
    return r;
  endfunction

  // Monitor: samples at the falling edge, pops on handshake.
  logic        prev_valid = 1'b0, prev_ready = 1'b0;
  logic [15:0] held_res;
  logic        held_ovf, held_unf;

  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        check("in_ready_while_done", 32'(in_ready), 32'd0);
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output: got result %04h with empty scoreboard", out_result);
        end else begin
          if (!prev_valid) check("latency", 32'(cyc - sb[0].acc_cyc), 32'(sb[0].lat));
          if (prev_valid && !prev_ready) begin
            check("stall_result_stable", 32'(out_result), 32'(held_res));
            check("stall_flags_stable", 32'({out_ovf, out_unf}), 32'({held_ovf, held_unf}));
          end
          if (out_ready) begin
            check("result", 32'(out_result), 32'(sb[0].res));
            check("ovf", 32'(out_ovf), 32'(sb[0].ovf));
            check("unf", 32'(out_unf), 32'(sb[0].unf));
            txn++;
            $display("txn %0d: result=%04h ovf=%0b unf=%0b (exp %04h %0b %0b) lat=%0d",
                     txn, out_result, out_ovf, out_unf, sb[0].res, sb[0].ovf, sb[0].unf, sb[0].lat);
            void'(sb.pop_front());
          end
        end
      end
      prev_valid = out_valid;
      prev_ready = out_ready;
      held_res   = out_result;
      held_ovf   = out_ovf;
      held_unf   = out_unf;
    end else begin
      prev_valid = 1'b0;
    end
  end

  // Downstream backpressure: random, or forced low for stall_hold cycles.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      if (stall_hold > 0) begin
        out_ready = 1'b0;
        stall_hold--;
      end else begin
        out_ready = ($urandom_range(0, 3) != 0);
      end
    end
  end

  task automatic send(input logic [10:0] m, input logic c, input logic [4:0] e, input logic s);
    exp_t x;
    int   wait_cyc;
    @(posedge clk);
    #2;
    in_mant = m; in_carry = c; in_exp = e; in_sign = s; in_valid = 1'b1;
    wait_cyc = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      wait_cyc++;
      if (wait_cyc > 300) begin
        errors++;
        $display("FAIL accept_timeout: in_ready stayed %0b for %0d cycles", in_ready, wait_cyc);
        break;
      end
    end
    x = model(m, c, e, s);
    x.acc_cyc = cyc + 1;
    sb.push_back(x);
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    in_mant  = 11'($urandom);
    in_carry = 1'($urandom);
    in_exp   = 5'($urandom);
    in_sign  = 1'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d items outstanding, required 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    logic [10:0] rm;
    rst_n = 1'b0; in_valid = 1'b0;
    in_mant = '0; in_carry = 1'b0; in_exp = '0; in_sign = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_result", 32'(out_result), 32'd0);
    check("reset_flags", 32'({out_ovf, out_unf}), 32'd0);
    @(posedge clk); #2; rst_n = 1'b1;

    send(11'h400, 1'b0, 5'd15, 1'b0);
    send(11'h000, 1'b1, 5'd15, 1'b0);
    send(11'h001, 1'b1, 5'd15, 1'b0);
    send(11'h001, 1'b0, 5'd15, 1'b1);
    send(11'h020, 1'b0, 5'd3,  1'b0);
    send(11'h123, 1'b1, 5'd30, 1'b1);
    send(11'h2ff, 1'b0, 5'd31, 1'b0);
    send(11'h100, 1'b0, 5'd0,  1'b1);
    drain();
    stall_hold = 8;
    send(11'h000, 1'b0, 5'd10, 1'b1);
    drain();

    // Reset during a long normalisation aborts the item.
    send(11'h001, 1'b0, 5'd15, 1'b1);
    repeat (3) @(posedge clk);
    #2; rst_n = 1'b0;
    sb.delete();
    @(negedge clk);
    check("midreset_out_valid", 32'(out_valid), 32'd0);
    check("midreset_in_ready", 32'(in_ready), 32'd1);
    check("midreset_result", 32'(out_result), 32'd0);
    @(posedge clk); #2; rst_n = 1'b1;
    @(negedge clk);
    check("postreset_in_ready", 32'(in_ready), 32'd1);
    check("postreset_out_valid", 32'(out_valid), 32'd0);
    send(11'h400, 1'b0, 5'd15, 1'b0);
    drain();

    for (int i = 0; i < 400; i++) begin
      rm = 11'($urandom) >> $urandom_range(0, 11);
      send(rm, 1'($urandom_range(0, 3) == 0), 5'($urandom), 1'($urandom));
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
